// File: rtl/alu_sched.sv
// Shares one external combinational 5-bit ALU between two requesters: IDLE -> EXEC -> RESP.
// Optional macro ALU_SCHED_RR_EN selects round-robin tie-breaking; undefined gives fixed priority to client 0.
module alu_sched (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Req0,
   input  logic       Req1,
   input  logic [1:0] Op0,
   input  logic [1:0] Op1,
   input  logic [4:0] A0,
   input  logic [4:0] B0,
   input  logic [4:0] A1,
   input  logic [4:0] B1,
   output logic       Gnt0,
   output logic       Gnt1,
   output logic       Done0,
   output logic       Done1,
   output logic [4:0] Result,
   output logic       Busy,
   output logic [1:0] AluSelect,
   output logic [4:0] AluA,
   output logic [4:0] AluB,
   input  logic [4:0] AluSum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic [1:0] sel_q, sel_d;
   logic [4:0] a_q, a_d;
   logic [4:0] b_q, b_d;
   logic [4:0] result_q, result_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   logic       done0_q, done0_d;
   logic       done1_q, done1_d;
   logic       busy_q, busy_d;
   logic       winner;

`ifdef ALU_SCHED_RR_EN
   // last_q = 1 means client 1 was served most recently
   logic last_q, last_d;

   always_comb begin
      winner = Req1;
      if (Req0 && Req1) begin
         winner = ~last_q;
      end
   end

   always_comb begin
      last_d = last_q;
      if (state_q == IDLE && (Req0 || Req1)) begin
         last_d = winner;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      winner = ~Req0;
   end
`endif

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      sel_d    = sel_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (Req0 || Req1) begin
               state_d = EXEC;
               owner_d = winner;
               sel_d   = winner ? Op1 : Op0;
               a_d     = winner ? A1 : A0;
               b_d     = winner ? B1 : B0;
               gnt0_d  = ~winner;
               gnt1_d  = winner;
            end
         end
         EXEC: begin
            state_d  = RESP;
            result_d = AluSum;
            done0_d  = ~owner_q;
            done1_d  = owner_q;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Busy is registered, so it is derived from the state being entered
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         sel_q    <= 2'b00;
         a_q      <= 5'd0;
         b_q      <= 5'd0;
         result_q <= 5'd0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         sel_q    <= sel_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
      end
   end

   assign Gnt0      = gnt0_q;
   assign Gnt1      = gnt1_q;
   assign Done0     = done0_q;
   assign Done1     = done1_q;
   assign Busy      = busy_q;
   assign Result    = result_q;
   assign AluSelect = sel_q;
   assign AluA      = a_q;
   assign AluB      = b_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched with a behavioural model of the shared ALU.
// Expected grants/results are queued by the stimulus and checked by a negedge monitor.
module tb_alu_sched;

   logic       Clk;
   logic       Rst_n;
   logic       Req0, Req1;
   logic [1:0] Op0, Op1;
   logic [4:0] A0, B0, A1, B1;
   logic       Gnt0, Gnt1, Done0, Done1, Busy;
   logic [4:0] Result, AluA, AluB, AluSum;
   logic [1:0] AluSelect;

   int         total = 0;
   int         bad = 0;
   int         busy_run = 0;
   int         gnt_exp[$];
   logic [5:0] done_exp[$];
   logic [5:0] de;

   alu_sched dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Req0(Req0), .Req1(Req1), .Op0(Op0), .Op1(Op1),
      .A0(A0), .B0(B0), .A1(A1), .B1(B1),
      .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1),
      .Result(Result), .Busy(Busy),
      .AluSelect(AluSelect), .AluA(AluA), .AluB(AluB), .AluSum(AluSum)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // External ALU: 00 AND, 01 ADD (mod 32), 10 OR, 11 XOR
   always_comb begin
      AluSum = 5'd0;
      case (AluSelect)
         2'b00: AluSum = AluA & AluB;
         2'b01: AluSum = AluA + AluB;
         2'b10: AluSum = AluA | AluB;
         default: AluSum = AluA ^ AluB;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (Rst_n) begin
         if (Gnt0 || Gnt1) begin
            chk("gnt_exclusive", {31'd0, Gnt0 & Gnt1}, 32'd0);
            if (gnt_exp.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_gnt: got client %0d required none", Gnt1);
            end else begin
               chk("gnt_owner", {31'd0, Gnt1}, gnt_exp.pop_front());
            end
         end
         if (Done0 || Done1) begin
            chk("done_exclusive", {31'd0, Done0 & Done1}, 32'd0);
            $display("done client=%0d result=%0d", Done1, Result);
            if (done_exp.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got client %0d result %0d required none", Done1, Result);
            end else begin
               de = done_exp.pop_front();
               chk("done_owner", {31'd0, Done1}, {31'd0, de[5]});
               chk("result", {27'd0, Result}, {27'd0, de[4:0]});
            end
         end
         if (Busy) begin
            busy_run++;
         end else begin
            if (busy_run != 0) chk("busy_len", busy_run, 32'd2);
            busy_run = 0;
         end
      end else begin
         busy_run = 0;
      end
   end

   task automatic do_op(input bit c, input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] exp_r, input bit change_a, input logic [4:0] a_new);
      @(negedge Clk);
      if (c) begin
         Req1 = 1'b1; Op1 = op; A1 = a; B1 = b;
      end else begin
         Req0 = 1'b1; Op0 = op; A0 = a; B0 = b;
      end
      gnt_exp.push_back(int'(c));
      done_exp.push_back({c, exp_r});
      @(negedge Clk);
      Req0 = 1'b0;
      Req1 = 1'b0;
      if (change_a) begin
         if (c) A1 = a_new;
         else   A0 = a_new;
      end
      @(negedge Clk);
   endtask

   initial begin
      Rst_n = 1'b0;
      Req0 = 1'b1; Req1 = 1'b1;
      Op0 = 2'b11; Op1 = 2'b11;
      A0 = 5'd5; B0 = 5'd3; A1 = 5'd22; B1 = 5'd12;

      repeat (2) @(negedge Clk);
      chk("rst_gnt0", {31'd0, Gnt0}, 32'd0);
      chk("rst_gnt1", {31'd0, Gnt1}, 32'd0);
      chk("rst_done0", {31'd0, Done0}, 32'd0);
      chk("rst_done1", {31'd0, Done1}, 32'd0);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_result", {27'd0, Result}, 32'd0);
      chk("rst_alusel", {30'd0, AluSelect}, 32'd0);
      chk("rst_alua", {27'd0, AluA}, 32'd0);
      chk("rst_alub", {27'd0, AluB}, 32'd0);

      // Contention with both requests held: 5^3=6 for client 0, 22^12=26 for client 1
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_SCHED_RR_EN
         gnt_exp.push_back(k % 2);
         done_exp.push_back((k % 2) ? {1'b1, 5'd26} : {1'b0, 5'd6});
`else
         gnt_exp.push_back(0);
         done_exp.push_back({1'b0, 5'd6});
`endif
      end
      #2 Rst_n = 1'b1;
      repeat (12) @(negedge Clk);
      Req0 = 1'b0;
      Req1 = 1'b0;
      @(negedge Clk);

      do_op(1'b0, 2'b01, 5'd20, 5'd15, 5'd3, 1'b0, 5'd0);
      do_op(1'b1, 2'b00, 5'b10110, 5'b01100, 5'b00100, 1'b0, 5'd0);
      do_op(1'b1, 2'b10, 5'b10110, 5'b01100, 5'b11110, 1'b0, 5'd0);
      do_op(1'b1, 2'b11, 5'b10110, 5'b01100, 5'b11010, 1'b0, 5'd0);
      do_op(1'b1, 2'b01, 5'b10110, 5'b01100, 5'b00010, 1'b0, 5'd0);
      do_op(1'b0, 2'b01, 5'd31, 5'd1, 5'd0, 1'b0, 5'd0);
      do_op(1'b0, 2'b01, 5'd5, 5'd3, 5'd8, 1'b1, 5'd9);

      // Reset during the grant cycle: grant is seen, done must never appear
      @(negedge Clk);
      Req0 = 1'b1; Op0 = 2'b01; A0 = 5'd5; B0 = 5'd3;
      gnt_exp.push_back(0);
      @(negedge Clk);
      Req0 = 1'b0;
      #2 Rst_n = 1'b0;
      @(negedge Clk);
      chk("midrst_busy", {31'd0, Busy}, 32'd0);
      chk("midrst_gnt0", {31'd0, Gnt0}, 32'd0);
      chk("midrst_done0", {31'd0, Done0}, 32'd0);
      @(negedge Clk);
      #2 Rst_n = 1'b1;
      repeat (3) @(negedge Clk);
      chk("postrst_busy", {31'd0, Busy}, 32'd0);
      chk("postrst_result", {27'd0, Result}, 32'd0);

      do_op(1'b1, 2'b00, 5'd7, 5'd12, 5'd4, 1'b0, 5'd0);
      repeat (3) @(negedge Clk);
      chk("result_hold", {27'd0, Result}, 32'd4);
      chk("alua_hold", {27'd0, AluA}, 32'd7);
      chk("gnt_queue_empty", gnt_exp.size(), 32'd0);
      chk("done_queue_empty", done_exp.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
